// File: rtl/mem_arbiter.sv
// Shares the external memory port between icache (client 0) and dcache (client 1), locking the data channel for write bursts.
// Define MEM_ARB_DCACHE_PRIO_EN for fixed dcache-wins-ties priority; default is round-robin.
module mem_arbiter #(
    parameter int ADDR_BITS  = 28,
    parameter int DATA_BITS  = 128,
    parameter int TAG_BITS   = 5,
    parameter int DATA_BEATS = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     c_req_valid,
    output logic [1:0]                     c_req_ready,
    input  logic [1:0]                     c_req_rw,
    input  logic [2*ADDR_BITS-1:0]         c_req_addr,
    input  logic [2*(TAG_BITS-1)-1:0]      c_req_tag,
    input  logic [1:0]                     c_data_valid,
    output logic [1:0]                     c_data_ready,
    input  logic [2*DATA_BITS-1:0]         c_data_bits,
    input  logic [2*(DATA_BITS/8)-1:0]     c_data_mask,
    output logic [1:0]                     c_resp_valid,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_rw,
    output logic [ADDR_BITS-1:0]           mem_req_addr,
    output logic [TAG_BITS-1:0]            mem_req_tag,
    output logic                           mem_req_data_valid,
    input  logic                           mem_req_data_ready,
    output logic [DATA_BITS-1:0]           mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]         mem_req_data_mask,
    input  logic                           mem_resp_valid,
    input  logic [TAG_BITS-1:0]            mem_resp_tag
);

    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int CTAG_BITS = TAG_BITS - 1;
    localparam int BEAT_W    = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WDATA = 1'b1;

    logic [0:0]        r_state;
    logic              r_owner;
    logic [BEAT_W-1:0] r_beat_cnt;

    logic w_winner;
    logic w_req_fire;
    logic w_beat_fire;
    logic w_unused_resp_tag;

`ifdef MEM_ARB_DCACHE_PRIO_EN
    assign w_winner = c_req_valid[1];
`else
    logic r_rr_last;

    // On a tie the client that did not win last time goes next.
    assign w_winner = (&c_req_valid) ? ~r_rr_last : c_req_valid[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last <= 1'b1;
        end else if (w_req_fire) begin
            r_rr_last <= w_winner;
        end
    end
`endif

    assign mem_req_rw   = w_winner ? c_req_rw[1] : c_req_rw[0];
    assign mem_req_addr = w_winner ? c_req_addr[2*ADDR_BITS-1:ADDR_BITS]
                                   : c_req_addr[ADDR_BITS-1:0];
    assign mem_req_tag  = {w_winner, (w_winner ? c_req_tag[2*CTAG_BITS-1:CTAG_BITS]
                                               : c_req_tag[CTAG_BITS-1:0])};

    assign mem_req_data_bits = r_owner ? c_data_bits[2*DATA_BITS-1:DATA_BITS]
                                       : c_data_bits[DATA_BITS-1:0];
    assign mem_req_data_mask = r_owner ? c_data_mask[2*MASK_BITS-1:MASK_BITS]
                                       : c_data_mask[MASK_BITS-1:0];

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        mem_req_valid      = 1'b0;
        c_req_ready        = 2'b00;
        mem_req_data_valid = 1'b0;
        c_data_ready       = 2'b00;
        if (!reset) begin
            if (r_state == ST_IDLE) begin
                mem_req_valid         = |c_req_valid;
                c_req_ready[w_winner] = mem_req_ready & (|c_req_valid);
            end else begin
                mem_req_data_valid    = c_data_valid[r_owner];
                c_data_ready[r_owner] = mem_req_data_ready;
            end
        end
    end

    assign w_req_fire  = mem_req_valid & mem_req_ready;
    assign w_beat_fire = mem_req_data_valid & mem_req_data_ready;

    // Responses are routed by tag MSB in any state; the low tag bits fan out outside this block.
    assign c_resp_valid = (mem_resp_valid && !reset)
                        ? (mem_resp_tag[TAG_BITS-1] ? 2'b10 : 2'b01) : 2'b00;
    assign w_unused_resp_tag = ^mem_resp_tag[TAG_BITS-2:0];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_beat_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_req_fire && mem_req_rw) begin
                r_owner    <= w_winner;
                r_beat_cnt <= '0;
                r_state    <= ST_WDATA;
            end
        end else if (w_beat_fire) begin
            if (r_beat_cnt == LAST_BEAT) begin
                r_beat_cnt <= '0;
                r_state    <= ST_IDLE;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration table, write-burst lock, response routing, reset mid-burst.
module tb_mem_arbiter;

    localparam int AB = 28;
    localparam int DB = 128;
    localparam int TB = 5;
    localparam int MB = DB / 8;

`ifdef MEM_ARB_DCACHE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        c_req_valid, c_req_ready, c_req_rw;
    logic [2*AB-1:0]   c_req_addr;
    logic [2*(TB-1)-1:0] c_req_tag;
    logic [1:0]        c_data_valid, c_data_ready, c_resp_valid;
    logic [2*DB-1:0]   c_data_bits;
    logic [2*MB-1:0]   c_data_mask;
    logic              mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AB-1:0]     mem_req_addr;
    logic [TB-1:0]     mem_req_tag;
    logic              mem_req_data_valid, mem_req_data_ready;
    logic [DB-1:0]     mem_req_data_bits;
    logic [MB-1:0]     mem_req_data_mask;
    logic              mem_resp_valid;
    logic [TB-1:0]     mem_resp_tag;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_rw(c_req_rw),
        .c_req_addr(c_req_addr), .c_req_tag(c_req_tag),
        .c_data_valid(c_data_valid), .c_data_ready(c_data_ready),
        .c_data_bits(c_data_bits), .c_data_mask(c_data_mask),
        .c_resp_valid(c_resp_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic tie(input logic rr_choice);
        return PRIO ? 1'b1 : rr_choice;
    endfunction

    function automatic logic [DB-1:0] beat_bits(input int b);
        logic [31:0] w;
        w = 32'hD00D_0000 + b[31:0];
        return {4{w}};
    endfunction

    function automatic logic [MB-1:0] beat_mask(input int b);
        return 16'hA5A0 + b[15:0];
    endfunction

    typedef struct {
        logic [1:0] vld;
        logic       rdy;
        logic       exp_valid;
        logic       exp_who;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [1:0] exp_ready;
        int beat;

        // Arbitration table (reads only): icache 0x100 tag 3, dcache 0x200 tag 7.
        vecs[0] = '{2'b11, 1'b1, 1'b1, tie(1'b0)};
        vecs[1] = '{2'b11, 1'b1, 1'b1, tie(1'b1)};
        vecs[2] = '{2'b11, 1'b1, 1'b1, tie(1'b0)};
        vecs[3] = '{2'b11, 1'b1, 1'b1, tie(1'b1)};
        vecs[4] = '{2'b10, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{2'b11, 1'b0, 1'b1, tie(1'b0)};
        vecs[6] = '{2'b11, 1'b1, 1'b1, tie(1'b0)};
        vecs[7] = '{2'b01, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{2'b11, 1'b1, 1'b1, tie(1'b1)};
        vecs[9] = '{2'b00, 1'b1, 1'b0, 1'b0};

        reset              = 1'b1;
        c_req_valid        = 2'b11;
        c_req_rw           = 2'b00;
        c_req_addr         = {28'h200, 28'h100};
        c_req_tag          = {4'h7, 4'h3};
        c_data_valid       = 2'b11;
        c_data_bits        = '1;
        c_data_mask        = '1;
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b1;
        mem_resp_valid     = 1'b1;
        mem_resp_tag       = 5'h10;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_req_valid",  mem_req_valid, 0);
        check("rst_req_ready",  c_req_ready, 0);
        check("rst_data_ready", c_data_ready, 0);
        check("rst_data_valid", mem_req_data_valid, 0);
        check("rst_resp_valid", c_resp_valid, 0);

        @(negedge clk);
        reset          = 1'b0;
        c_req_valid    = 2'b00;
        c_data_valid   = 2'b00;
        mem_resp_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            c_req_valid   = vecs[i].vld;
            mem_req_ready = vecs[i].rdy;
            #1;
            exp_ready = (vecs[i].exp_valid && vecs[i].rdy) ? (vecs[i].exp_who ? 2'b10 : 2'b01) : 2'b00;
            check($sformatf("arb%0d_valid", i), mem_req_valid, vecs[i].exp_valid);
            check($sformatf("arb%0d_ready", i), c_req_ready, exp_ready);
            if (vecs[i].exp_valid) begin
                check($sformatf("arb%0d_tag", i), mem_req_tag, vecs[i].exp_who ? 5'h17 : 5'h03);
                check($sformatf("arb%0d_addr", i), mem_req_addr, vecs[i].exp_who ? 28'h200 : 28'h100);
                check($sformatf("arb%0d_rw", i), mem_req_rw, 0);
            end
        end

        // dcache write to 0x40; icache read must wait for the burst to end.
        @(negedge clk);
        c_req_valid        = 2'b10;
        c_req_rw           = 2'b10;
        c_req_addr         = {28'h40, 28'h100};
        c_req_tag          = {4'h5, 4'h3};
        mem_req_ready      = 1'b1;
        mem_req_data_ready = 1'b0;
        #1;
        check("wr_req_valid", mem_req_valid, 1);
        check("wr_req_ready", c_req_ready, 2'b10);
        check("wr_rw",        mem_req_rw, 1);
        check("wr_addr",      mem_req_addr, 28'h40);
        check("wr_tag",       mem_req_tag, 5'h15);

        @(negedge clk);
        c_req_valid  = 2'b01;
        c_req_rw     = 2'b00;
        c_data_valid = 2'b11;
        beat = 0;
        for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_req_data_ready = cyc[0];
            c_data_bits        = {beat_bits(beat), {DB{1'b1}}};
            c_data_mask        = {beat_mask(beat), {MB{1'b1}}};
            mem_resp_valid     = (cyc == 2 || cyc == 4);
            mem_resp_tag       = (cyc == 4) ? 5'b1_0011 : 5'b0_0001;
            #1;
            check("wr_lock_req_valid", mem_req_valid, 0);
            check("wr_lock_req_ready", c_req_ready, 0);
            check("wr_beat_valid",     mem_req_data_valid, 1);
            check("wr_data_ready",     c_data_ready, cyc[0] ? 2'b10 : 2'b00);
            check("wr_beat_bits",      mem_req_data_bits, beat_bits(beat));
            check("wr_beat_mask",      mem_req_data_mask, beat_mask(beat));
            check("wr_resp_valid",     c_resp_valid,
                  (cyc == 4) ? 2'b10 : ((cyc == 2) ? 2'b01 : 2'b00));
            if (cyc[0]) beat++;
        end
        check("wr_beat_count", beat, 4);

        @(negedge clk);
        mem_resp_valid     = 1'b0;
        mem_req_data_ready = 1'b1;
        #1;
        check("post_wr_req_valid",  mem_req_valid, 1);
        check("post_wr_req_ready",  c_req_ready, 2'b01);
        check("post_wr_tag",        mem_req_tag, 5'h03);
        check("post_wr_data_valid", mem_req_data_valid, 0);
        check("post_wr_data_ready", c_data_ready, 0);

        // Reset after three beats of a write, then a fresh write needs all four beats.
        @(negedge clk);
        c_req_valid  = 2'b10;
        c_req_rw     = 2'b10;
        c_data_valid = 2'b00;
        #1;
        check("rb_req_ready", c_req_ready, 2'b10);
        @(negedge clk);
        c_req_valid  = 2'b00;
        c_data_valid = 2'b10;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) @(negedge clk);
            c_data_bits = {beat_bits(b), {DB{1'b1}}};
            #1;
            check("rb_beat_valid", mem_req_data_valid, 1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rb_rst_data_valid", mem_req_data_valid, 0);
        check("rb_rst_data_ready", c_data_ready, 0);
        @(negedge clk);
        reset         = 1'b0;
        c_req_valid   = 2'b11;
        c_req_rw      = 2'b00;
        mem_req_ready = 1'b0;
        #1;
        check("rb_idle_data_valid", mem_req_data_valid, 0);
        check("rb_idle_req_valid",  mem_req_valid, 1);
        check("rb_first_tie_tag",   mem_req_tag, tie(1'b0) ? 5'h15 : 5'h03);

        @(negedge clk);
        c_req_valid   = 2'b10;
        c_req_rw      = 2'b10;
        mem_req_ready = 1'b1;
        #1;
        check("fresh_req_ready", c_req_ready, 2'b10);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            c_req_valid = 2'b00;
            c_data_bits = {beat_bits(b + 8), {DB{1'b1}}};
            #1;
            check($sformatf("fresh_beat%0d_valid", b), mem_req_data_valid, 1);
            check($sformatf("fresh_beat%0d_ready", b), c_data_ready, 2'b10);
            check($sformatf("fresh_beat%0d_bits", b),  mem_req_data_bits, beat_bits(b + 8));
        end
        @(negedge clk); #1;
        check("fresh_done_data_valid", mem_req_data_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
